spi_bus_arbiter: RTL

Parametrised successor to the two-way SPI line mux in the hardware-performance harness. Shares one physical SD-SPI bus among `N_MASTERS` masters (autotest, one or more UUTs, a debug master) through request/grant tenure, round-robin fairness and a guarded handover with `cs` forced high. It also measures each tenure's length in clock cycles for the performance display. It sits between the masters and the pads, replacing the per-signal muxes.

---
 rtl/spi_arb_pkg.sv | 25 ++
 rtl/spi_bus_arbiter_rr.sv | 27 ++
 rtl/spi_bus_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI bus arbiter.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  localparam logic IDLE_CS   = 1'b1;
  localparam logic IDLE_MOSI = 1'b1;

  localparam int unsigned MAX_MASTERS = 8;

  // Index of the set bit in a one-hot vector (zero when no bit is set).
  function automatic logic [2:0] onehot2idx(input logic [MAX_MASTERS-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_MASTERS; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/spi_bus_arbiter_rr.sv
// Combinational round-robin picker: first requester at index >= ptr, wrapping.
module rr_arbiter #(
  parameter  int unsigned N_MASTERS = 2,
  localparam int unsigned ID_W      = $clog2(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] req_i,
  input  logic [ID_W-1:0]      ptr_i,
  output logic [N_MASTERS-1:0] gnt_o,
  output logic                 valid_o
);

  // Scan from the pointer upward; the first hit wins.
  always_comb begin : pick
    logic [ID_W-1:0] idx;
    gnt_o   = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      idx = ID_W'((32'(ptr_i) + k) % N_MASTERS);
      if (!valid_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one SD-SPI bus among N masters with round-robin tenure, a guarded
// handover with cs high, and per-tenure cycle measurement.
module spi_bus_arbiter #(
  parameter  int unsigned N_MASTERS    = 2,
  parameter  int unsigned CNT_W        = 32,
  parameter  int unsigned GUARD_CYCLES = 8,
  parameter  logic        CPOL         = 1'b0,
  localparam int unsigned ID_W         = $clog2(N_MASTERS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_MASTERS-1:0] req,
  output logic [N_MASTERS-1:0] grant,
  output logic [ID_W-1:0]      owner_id,
  input  logic [N_MASTERS-1:0] m_sclk,
  input  logic [N_MASTERS-1:0] m_mosi,
  input  logic [N_MASTERS-1:0] m_cs,
  output logic [N_MASTERS-1:0] m_miso,
  output logic                 sclk,
  output logic                 mosi,
  output logic                 cs,
  input  logic                 miso,
  output logic [CNT_W-1:0]     tenure_cycles,
  output logic                 tenure_valid
);
  import spi_arb_pkg::*;

  localparam int unsigned GD_W = $clog2(GUARD_CYCLES + 1);

  arb_state_e           state_q,  state_d;
  logic [N_MASTERS-1:0] grant_q,  grant_d;
  logic [ID_W-1:0]      owner_q,  owner_d;
  logic [ID_W-1:0]      ptr_q,    ptr_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;
  logic [CNT_W-1:0]     tenure_q, tenure_d;
  logic                 tvalid_q, tvalid_d;
  logic [GD_W-1:0]      guard_q,  guard_d;

  logic [N_MASTERS-1:0] win_oh;
  logic                 win_valid;

  rr_arbiter #(
    .N_MASTERS(N_MASTERS)
  ) u_rr (
    .req_i  (req),
    .ptr_i  (ptr_q),
    .gnt_o  (win_oh),
    .valid_o(win_valid)
  );

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      tenure_q <= '0;
      tvalid_q <= 1'b0;
      guard_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      tenure_q <= tenure_d;
      tvalid_q <= tvalid_d;
      guard_q  <= guard_d;
    end
  end

  // Tenure FSM: arbitrate, count while owned, report on release, then guard.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    tenure_d = tenure_q;
    tvalid_d = 1'b0;
    guard_d  = guard_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d = OWN;
          grant_d = win_oh;
          owner_d = ID_W'(onehot2idx(MAX_MASTERS'(win_oh)));
          cnt_d   = CNT_W'(1);
        end
      end
      OWN: begin
        if (!req[owner_q]) begin
          state_d  = DRAIN;
          grant_d  = '0;
          tenure_d = cnt_q;
          tvalid_d = 1'b1;
          guard_d  = GD_W'(GUARD_CYCLES - 1);
          if (32'(owner_q) == N_MASTERS - 1) ptr_d = '0;
          else                               ptr_d = owner_q + ID_W'(1);
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (guard_q == '0) state_d = IDLE;
        else               guard_d = guard_q - GD_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Pad mux: owner pass-through in OWN, idle levels otherwise.
  always_comb begin
    sclk   = CPOL;
    mosi   = IDLE_MOSI;
    cs     = IDLE_CS;
    m_miso = '1;
    if (state_q == OWN) begin
      sclk            = m_sclk[owner_q];
      mosi            = m_mosi[owner_q];
      cs              = m_cs[owner_q];
      m_miso[owner_q] = miso;
    end
  end

  assign grant         = grant_q;
  assign owner_id      = owner_q;
  assign tenure_cycles = tenure_q;
  assign tenure_valid  = tvalid_q;

endmodule
